// File: rtl/tx_sink_pkg.sv
// Shared definitions for the TX stream sink: control-word bit positions,
// default parameters and the control-word decoder.
package tx_sink_pkg;

    localparam int CTL_ENABLE       = 0;
    localparam int CTL_CLR_UNDERRUN = 1;
    localparam int CTL_FLUSH        = 2;

    localparam int DEF_SAMPLE_DIV    = 2500;
    localparam int DEF_PWM_BITS      = 8;
    localparam int DEF_AM_FIFO_DEPTH = 4;

    typedef struct packed {
        logic enable;
        logic clr_underrun;
        logic flush;
    } ctl_t;

    function automatic ctl_t decode_ctl(input logic [2:0] bits);
        ctl_t c;
        c.enable       = bits[CTL_ENABLE];
        c.clr_underrun = bits[CTL_CLR_UNDERRUN];
        c.flush        = bits[CTL_FLUSH];
        return c;
    endfunction

endpackage

// File: rtl/tx_am_fifo.sv
// Small synchronous FIFO for AM samples. Flush empties it; a push landing on
// the flush edge survives as the only entry. Push+pop on a full FIFO is allowed.
module tx_am_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;

    logic          w_do_pop;
    logic          w_do_push;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd];

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign w_wr_en   = i_flush ? i_push : w_do_push;
    assign w_wr_addr = i_flush ? '0 : r_wr;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= i_push ? PTR_ONE : '0;
            r_count <= i_push ? CNT_ONE : '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tx_stream_sink.sv
// Consumer of the freq/am/ctl stb-ack streams: drives a 32-bit NCO square wave
// on rf_out and a PWM envelope on pwm_out, with AM samples paced by a tick.
module tx_stream_sink
    import tx_sink_pkg::*;
#(
    parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
    parameter int AM_FIFO_DEPTH = DEF_AM_FIFO_DEPTH,
    parameter int PWM_BITS      = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         input_freq,
    input  logic                input_freq_stb,
    output logic                input_freq_ack,
    input  logic [31:0]         input_am,
    input  logic                input_am_stb,
    output logic                input_am_ack,
    input  logic [31:0]         input_ctl,
    input  logic                input_ctl_stb,
    output logic                input_ctl_ack,
    output logic                rf_out,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] am_level,
    output logic                underrun
);
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(AM_FIFO_DEPTH) + 1;
    localparam logic [TW-1:0]       TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0]       TICK_ONE  = 1;
    localparam logic [PWM_BITS-1:0] PWM_ONE   = 1;

    logic                r_freq_ack;
    logic                r_am_ack;
    logic                r_ctl_ack;
    logic [TW-1:0]       r_tick_cnt;
    logic [31:0]         r_pending_inc;
    logic [31:0]         r_inc;
    logic [31:0]         r_phase;
    logic                r_enable;
    logic                r_underrun;
    logic [PWM_BITS-1:0] r_am_level;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_rf_out;
    logic                r_pwm_out;

    logic                w_freq_xfer;
    logic                w_am_xfer;
    logic                w_ctl_xfer;
    ctl_t                w_ctl;
    logic                w_tick;
    logic                w_flush;
    logic [PWM_BITS-1:0] w_fifo_data;
    logic [CW-1:0]       w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_unused_bits;

    assign w_freq_xfer = input_freq_stb & r_freq_ack;
    assign w_am_xfer   = input_am_stb & r_am_ack;
    assign w_ctl_xfer  = input_ctl_stb & r_ctl_ack;
    assign w_ctl       = decode_ctl(input_ctl[2:0]);
    assign w_tick      = (r_tick_cnt == TICK_LAST);
    assign w_flush     = w_ctl_xfer & w_ctl.flush;

    assign w_unused_bits = ^{input_am[31:PWM_BITS], input_ctl[31:3], w_fifo_count};

    tx_am_fifo #(
        .DEPTH (AM_FIFO_DEPTH),
        .W     (PWM_BITS)
    ) u_am_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_am_xfer),
        .i_data  (input_am[PWM_BITS-1:0]),
        .i_pop   (w_tick),
        .i_flush (w_flush),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_freq_ack    <= 1'b0;
            r_am_ack      <= 1'b0;
            r_ctl_ack     <= 1'b0;
            r_tick_cnt    <= '0;
            r_pending_inc <= '0;
            r_inc         <= '0;
            r_phase       <= '0;
            r_enable      <= 1'b0;
            r_underrun    <= 1'b0;
            r_am_level    <= '0;
            r_pwm_cnt     <= '0;
            r_rf_out      <= 1'b0;
            r_pwm_out     <= 1'b0;
        end else begin
            // Acks are one-cycle pulses; the ~ack term forces an idle cycle after each transfer.
            r_freq_ack <= input_freq_stb & ~r_freq_ack;
            r_ctl_ack  <= input_ctl_stb & ~r_ctl_ack;
            r_am_ack   <= input_am_stb & ~r_am_ack & ~w_fifo_full;

            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_ONE;

            if (w_freq_xfer) begin
                r_pending_inc <= input_freq;
            end
            if (w_tick) begin
                r_inc <= r_pending_inc;
            end
            if (r_enable) begin
                r_phase <= r_phase + r_inc;
            end
            if (w_ctl_xfer) begin
                r_enable <= w_ctl.enable;
            end

            if (w_tick && !w_fifo_empty) begin
                r_am_level <= w_fifo_data;
            end
            // A clear request on the same edge as an underrun tick takes priority.
            if (w_ctl_xfer && w_ctl.clr_underrun) begin
                r_underrun <= 1'b0;
            end else if (w_tick && w_fifo_empty && r_enable) begin
                r_underrun <= 1'b1;
            end

            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
            r_rf_out  <= r_phase[31] & r_enable;
            r_pwm_out <= (r_pwm_cnt < r_am_level) & r_enable;
        end
    end

    assign input_freq_ack = r_freq_ack;
    assign input_am_ack   = r_am_ack;
    assign input_ctl_ack  = r_ctl_ack;
    assign rf_out         = r_rf_out;
    assign pwm_out        = r_pwm_out;
    assign am_level       = r_am_level;
    assign underrun       = r_underrun;

endmodule

// File: tb/tb_tx_stream_sink.sv
// Randomized self-checking bench for tx_stream_sink with a transaction-level
// model of the AM FIFO, applied level, enable and underrun flag.
module tb_tx_stream_sink;
    localparam int SDIV  = 16;
    localparam int DEPTH = 4;
    localparam int PB    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   input_freq = '0;
    logic          input_freq_stb = 1'b0;
    logic [31:0]   input_am = '0;
    logic          input_am_stb = 1'b0;
    logic [31:0]   input_ctl = '0;
    logic          input_ctl_stb = 1'b0;
    logic          input_freq_ack;
    logic          input_am_ack;
    logic          input_ctl_ack;
    logic          rf_out;
    logic          pwm_out;
    logic [PB-1:0] am_level;
    logic          underrun;

    always #5 clk = ~clk;

    tx_stream_sink #(
        .SAMPLE_DIV    (SDIV),
        .AM_FIFO_DEPTH (DEPTH),
        .PWM_BITS      (PB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .input_freq     (input_freq),
        .input_freq_stb (input_freq_stb),
        .input_freq_ack (input_freq_ack),
        .input_am       (input_am),
        .input_am_stb   (input_am_stb),
        .input_am_ack   (input_am_ack),
        .input_ctl      (input_ctl),
        .input_ctl_stb  (input_ctl_stb),
        .input_ctl_ack  (input_ctl_ack),
        .rf_out         (rf_out),
        .pwm_out        (pwm_out),
        .am_level       (am_level),
        .underrun       (underrun)
    );

    int tests = 0;
    int fails = 0;
    int edges = 0;

    // Reference model: FIFO contents as a queue, plus level/enable/underrun.
    logic [7:0] m_q[$];
    logic [7:0] m_level = '0;
    bit         m_enable = 1'b0;
    bit         m_underrun = 1'b0;

    // One clock edge; applies the sample-tick rule to the model, then settles.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            edges = 0;
            m_q.delete();
            m_level = '0;
            m_enable = 1'b0;
            m_underrun = 1'b0;
        end else begin
            edges++;
            if (edges % SDIV == 0) begin
                if (m_q.size() > 0) m_level = m_q.pop_front();
                else if (m_enable) m_underrun = 1'b1;
            end
        end
        #1;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (edges % SDIV != 0 && n < 40);
        if (edges % SDIV != 0) begin
            tests++; fails++;
            $display("FAIL wait_tick: no sample tick within %0d cycles", n);
        end
    endtask

    // Drives any combination of the three streams; each completes on its own stb&&ack edge.
    task automatic xfer(input bit df, input logic [31:0] f,
                        input bit da, input logic [31:0] a,
                        input bit dc, input logic [31:0] c);
        bit pf = df, pa = da, pc = dc;
        bit af, aa, ac;
        int n = 0;
        input_freq = f; input_am = a; input_ctl = c;
        input_freq_stb = df; input_am_stb = da; input_ctl_stb = dc;
        while ((pf || pa || pc) && n < 60) begin
            af = input_freq_ack; aa = input_am_ack; ac = input_ctl_ack;
            step();
            n++;
            if (pf && af) begin pf = 0; input_freq_stb = 1'b0; end
            if (pc && ac) begin
                pc = 0; input_ctl_stb = 1'b0;
                if (c[1]) m_underrun = 1'b0;
                if (c[2]) m_q.delete();
                m_enable = c[0];
            end
            if (pa && aa) begin
                pa = 0; input_am_stb = 1'b0;
                m_q.push_back(a[7:0]);
            end
        end
        if (pf || pa || pc) begin
            tests++; fails++;
            $display("FAIL xfer_timeout: pending f=%0b a=%0b c=%0b after %0d cycles", pf, pa, pc, n);
            input_freq_stb = 1'b0; input_am_stb = 1'b0; input_ctl_stb = 1'b0;
        end
    endtask

    task automatic test_reset();
        bit bad_ack = 0;
        rst = 1'b1;
        input_freq_stb = 1'b1; input_am_stb = 1'b1; input_ctl_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if ({input_freq_ack, input_am_ack, input_ctl_ack} !== 3'b000) bad_ack = 1;
        end
        tests++;
        if (bad_ack) begin fails++; $display("FAIL reset_acks: got an ack during reset, want none"); end
        tests++;
        if ({rf_out, pwm_out, underrun} !== 3'b000) begin
            fails++; $display("FAIL reset_outs: rf/pwm/underrun=%b want 000", {rf_out, pwm_out, underrun});
        end
        tests++;
        if (am_level !== 8'h00) begin fails++; $display("FAIL reset_level: got %h want 00", am_level); end
        rst = 1'b0;
        step();
        tests++;
        if ({input_freq_ack, input_am_ack, input_ctl_ack} !== 3'b111) begin
            fails++; $display("FAIL first_ack: got %b want 111", {input_freq_ack, input_am_ack, input_ctl_ack});
        end
        // Withdraw before the transfer edge: nothing is accepted and acks fall.
        input_freq_stb = 1'b0; input_am_stb = 1'b0; input_ctl_stb = 1'b0;
        step();
        tests++;
        if ({input_freq_ack, input_am_ack, input_ctl_ack} !== 3'b000) begin
            fails++; $display("FAIL ack_drop: got %b want 000", {input_freq_ack, input_am_ack, input_ctl_ack});
        end
    endtask

    task automatic test_back_to_back();
        bit prev = 0, bad = 0;
        int highs = 0;
        input_freq_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            input_freq = $urandom;
            step();
            if (input_freq_ack && prev) bad = 1;
            highs += int'(input_freq_ack);
            prev = input_freq_ack;
        end
        input_freq_stb = 1'b0;
        step();
        tests++;
        if (bad) begin fails++; $display("FAIL b2b_idle: ack high on consecutive cycles, want gap"); end
        tests++;
        if (highs != 5) begin fails++; $display("FAIL b2b_rate: got %0d acks want 5", highs); end
    endtask

    task automatic test_nco();
        int k1, k2, p, ones;
        bit ok, zero_ok;
        logic s [8];
        k1 = 30 + int'($urandom % 2);
        k2 = 61 - k1;
        xfer(0, 0, 0, 0, 1, 32'h1);
        xfer(1, 32'd1 << k1, 0, 0, 0, 0);
        wait_tick();
        // New word lands mid-period; the old increment must persist until the next tick.
        xfer(1, 32'd1 << k2, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 8; i++) begin s[i] = rf_out; step(); end
        p = 1 << (32 - k1);
        ok = 1; ones = 0;
        for (int t = 0; t < 8; t++) begin
            if (t + p < 8 && s[t] !== s[t+p]) ok = 0;
            if (t + p/2 < 8 && s[t] === s[t+p/2]) ok = 0;
            if (t < 4) ones += int'(s[t]);
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL nco_period_old: rf pattern not period %0d before tick", p); end
        tests++;
        if (ones != 2) begin fails++; $display("FAIL nco_duty: got %0d high of 4 want 2", ones); end
        wait_tick();
        step(); step();
        for (int i = 0; i < 8; i++) begin s[i] = rf_out; step(); end
        p = 1 << (32 - k2);
        ok = 1;
        for (int t = 0; t < 8; t++) begin
            if (t + p < 8 && s[t] !== s[t+p]) ok = 0;
            if (t + p/2 < 8 && s[t] === s[t+p/2]) ok = 0;
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL nco_period_new: rf pattern not period %0d after tick", p); end
        xfer(0, 0, 0, 0, 1, 32'h0);
        step();
        zero_ok = 1;
        for (int i = 0; i < 8; i++) begin
            if (rf_out !== 1'b0 || pwm_out !== 1'b0) zero_ok = 0;
            step();
        end
        tests++;
        if (!zero_ok) begin fails++; $display("FAIL disable_gate: rf/pwm active while disabled, want 0"); end
    endtask

    task automatic test_fifo();
        logic [7:0] vals [4] = '{8'h40, 8'h80, 8'hFF, 8'h00};
        logic [7:0] after [4] = '{8'h80, 8'hFF, 8'h00, 8'h11};
        bit bad = 0;
        int n = 0;
        xfer(0, 0, 0, 0, 1, 32'h5);
        wait_tick();
        for (int i = 0; i < 4; i++) xfer(0, 0, 1, {$urandom} & 32'hFFFF_FF00 | {24'h0, vals[i]}, 0, 0);
        input_am = 32'hABCD_EF11;
        input_am_stb = 1'b1;
        while (edges % SDIV != 0 && n < 20) begin
            step(); n++;
            if (input_am_ack !== 1'b0) bad = 1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL am_full_ack: ack raised while FIFO full, want 0"); end
        tests++;
        if (am_level !== 8'h40) begin fails++; $display("FAIL am_first_pop: got %h want 40", am_level); end
        n = 0;
        while (input_am_ack !== 1'b1 && n < 2) begin step(); n++; end
        tests++;
        if (input_am_ack !== 1'b1) begin fails++; $display("FAIL am_ack_after_pop: got %b want 1 within 2 cycles", input_am_ack); end
        step();
        m_q.push_back(8'h11);
        input_am_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            tests++;
            if (am_level !== after[i]) begin fails++; $display("FAIL am_order[%0d]: got %h want %h", i, am_level, after[i]); end
        end
    endtask

    task automatic test_pwm();
        logic [7:0] lv [3];
        int cnt;
        lv[0] = 8'(1 + ($urandom % 254));
        lv[1] = 8'hFF;
        lv[2] = 8'h00;
        for (int j = 0; j < 3; j++) begin
            xfer(0, 0, 0, 0, 1, 32'h5);
            xfer(0, 0, 1, {24'h0, lv[j]}, 0, 0);
            wait_tick();
            step(); step();
            tests++;
            if (am_level !== lv[j]) begin fails++; $display("FAIL pwm_level[%0d]: got %h want %h", j, am_level, lv[j]); end
            cnt = 0;
            for (int i = 0; i < 256; i++) begin cnt += int'(pwm_out); step(); end
            tests++;
            if (cnt != int'(lv[j])) begin fails++; $display("FAIL pwm_duty[%0d]: got %0d/256 want %0d/256", j, cnt, lv[j]); end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] lvl;
        xfer(0, 0, 0, 0, 1, 32'h7);
        lvl = am_level;
        tests++;
        if (underrun !== 1'b0) begin fails++; $display("FAIL ur_cleared: got %b want 0", underrun); end
        wait_tick();
        tests++;
        if (underrun !== 1'b1) begin fails++; $display("FAIL ur_set: got %b want 1", underrun); end
        tests++;
        if (am_level !== lvl) begin fails++; $display("FAIL ur_level_held: got %h want %h", am_level, lvl); end
        xfer(0, 0, 0, 0, 1, 32'h3);
        tests++;
        if (underrun !== 1'b0) begin fails++; $display("FAIL ur_clear_edge: got %b want 0", underrun); end
        wait_tick();
        tests++;
        if (underrun !== 1'b1) begin fails++; $display("FAIL ur_enable_kept: got %b want 1", underrun); end
        // Land the clear exactly on a tick edge that would set the flag.
        while (edges % SDIV != SDIV - 2) step();
        xfer(0, 0, 0, 0, 1, 32'h3);
        tests++;
        if (underrun !== 1'b0 || m_underrun !== 1'b0) begin
            fails++; $display("FAIL ur_clear_wins: got %b want 0 (edge %0d)", underrun, edges % SDIV);
        end
        xfer(0, 0, 0, 0, 1, 32'h2);
        wait_tick();
        tests++;
        if (underrun !== 1'b0) begin fails++; $display("FAIL ur_disabled: got %b want 0", underrun); end
        tests++;
        if (am_level !== lvl) begin fails++; $display("FAIL ur_disabled_level: got %h want %h", am_level, lvl); end
    endtask

    task automatic test_flush_push();
        logic [7:0] w;
        w = 8'($urandom);
        xfer(0, 0, 0, 0, 1, 32'h5);
        wait_tick();
        for (int i = 0; i < 3; i++) xfer(0, 0, 1, {24'h0, 8'(w + 8'(i + 1))}, 0, 0);
        xfer(0, 0, 1, {24'h0, w}, 1, 32'h5);
        wait_tick();
        tests++;
        if (am_level !== w) begin fails++; $display("FAIL flush_push_pop: got %h want %h", am_level, w); end
        wait_tick();
        tests++;
        if (am_level !== w || underrun !== 1'b1) begin
            fails++; $display("FAIL flush_push_count1: level %h ur %b want %h 1", am_level, underrun, w);
        end
    endtask

    task automatic test_random();
        logic [31:0] c;
        for (int i = 0; i < 200; i++) begin
            case ($urandom % 5)
                0: xfer(1, $urandom, 0, 0, 0, 0);
                1, 2: xfer(0, 0, 1, $urandom, 0, 0);
                3: begin
                    c = $urandom;
                    c[0] = ($urandom % 4) != 0;
                    c[2] = ($urandom % 4) == 0;
                    xfer(0, 0, 0, 0, 1, c);
                end
                default: begin
                    int n = 1 + int'($urandom % 6);
                    for (int k = 0; k < n; k++) step();
                end
            endcase
            tests++;
            if (am_level !== m_level) begin fails++; $display("FAIL rand_level[%0d]: got %h want %h", i, am_level, m_level); end
            tests++;
            if (underrun !== m_underrun) begin fails++; $display("FAIL rand_underrun[%0d]: got %b want %b", i, underrun, m_underrun); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_nco();
        test_fifo();
        test_pwm();
        test_underrun();
        test_flush_push();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
